elastic_buffer_sc: RTL and testbench
====================================

ELASTIC_BUFFER_SC -- requirements
Module: elastic_buffer_sc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 10, symbol width.
REQ-002 The block SHALL have parameter BUFFER_DEPTH, default 16, entry count, power of two, at least 8.
REQ-003 The block SHALL have parameter SKP_SYMBOL, default 10'h0f3, the skip symbol and the idle fill value.
REQ-004 The block SHALL have parameter TARGET_LEVEL, default BUFFER_DEPTH/2, the nominal fill level.
REQ-005 The block SHALL have parameter HYSTERESIS, default 2, the dead band around TARGET_LEVEL.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits, the write symbol.
REQ-009 The block SHALL have port data_in_valid, input, 1 bit, the write request.
REQ-010 The block SHALL have port rd_en, input, 1 bit, the read request.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits, registered, the read symbol.
REQ-012 The block SHALL have port data_out_valid, output, 1 bit, registered, high when data_out holds a real or inserted symbol.
REQ-013 The block SHALL have ports full and empty, output, 1 bit each, combinational from level (level==BUFFER_DEPTH, level==0).
REQ-014 The block SHALL have port level, output, $clog2(BUFFER_DEPTH)+1 bits, the current occupancy.
REQ-015 The block SHALL have ports skp_added, skp_removed, overflow and underflow, output, 1 bit each, registered one-cycle pulses.

Function
REQ-016 Write and read pointers SHALL be internal, $clog2(BUFFER_DEPTH) bits, and SHALL wrap modulo BUFFER_DEPTH.
REQ-017 A write SHALL be accepted when data_in_valid=1 and level<BUFFER_DEPTH, judged on pre-edge level regardless of a concurrent read.
REQ-018 SKP removal: data_in==SKP_SYMBOL, data_in_valid=1 and level>TARGET_LEVEL+HYSTERESIS -> symbol not stored, write pointer held, skp_removed=1 next cycle.
REQ-019 Overflow: data_in_valid=1, level==BUFFER_DEPTH and not removed per REQ-018 -> symbol discarded, overflow=1 next cycle, stored contents unchanged.
REQ-020 The FSM SHALL have states PRIME and RUN; PRIME is the reset state.
REQ-021 In PRIME, reads SHALL not pop, data_out=SKP_SYMBOL and data_out_valid=0; PRIME->RUN when level>=TARGET_LEVEL (pre-edge).
REQ-022 In RUN with rd_en=1, level>0, head==SKP_SYMBOL and level<TARGET_LEVEL-HYSTERESIS: SKP insertion -> data_out=SKP_SYMBOL, data_out_valid=1, read pointer held, skp_added=1 next cycle.
REQ-023 In RUN with rd_en=1, level>0 and no insertion: pop -> data_out=head symbol, data_out_valid=1, read pointer +1.
REQ-024 In RUN with rd_en=1 and level==0: data_out=SKP_SYMBOL, data_out_valid=0, underflow=1 next cycle, RUN->PRIME.
REQ-025 With rd_en=0, data_out SHALL hold its value and data_out_valid SHALL be 0.
REQ-026 Read latency SHALL be one cycle from rd_en to data_out.
REQ-027 level SHALL increment on an accepted write only, decrement on a pop only, and remain unchanged when both or neither occur.
REQ-028 A same-cycle write into an empty buffer SHALL NOT be readable that cycle; it is readable from the next cycle.
REQ-029 At most one SKP SHALL be inserted or removed per cycle on each side; insertion and removal in the same cycle are both permitted.

Reset
REQ-030 rst=1 SHALL immediately force pointers=0, level=0, state=PRIME, data_out=SKP_SYMBOL, and data_out_valid, skp_added, skp_removed, overflow and underflow to 0.
REQ-031 Buffer storage SHALL NOT be reset; contents after reset are don't-care and never read before being written.
REQ-032 Reset asserted mid-operation SHALL discard all stored symbols and in-flight pulses, and the block SHALL restart in PRIME.

Verification (BUFFER_DEPTH=16, TARGET_LEVEL=8, HYSTERESIS=2)
REQ-033 Priming: 8 writes 0x001..0x008 with rd_en=1 throughout -> data_out_valid=0 until level=8, then 0x001,0x002,... in order with 1-cycle latency.
REQ-034 Removal: fill to 12, write SKP_SYMBOL -> level stays 12, skp_removed pulses once; a SKP written at level 10 is stored.
REQ-035 Insertion: level=5, head=SKP_SYMBOL, rd_en=1 -> SKP output with valid=1, skp_added=1, level stays 5; at level 6 the same head is popped.
REQ-036 Overflow: 16 non-SKP writes with no reads, then write 0x155 -> overflow=1, full=1, level=16, 0x155 never appears on data_out.
REQ-037 Underflow: in RUN, drain to 0, rd_en=1 -> underflow=1, data_out=0x0f3, valid=0, state returns to PRIME.
REQ-038 Wrap and reset: 40 interleaved simultaneous write/read cycles at level 8 -> level constant, data order preserved across wrap; rst mid-stream -> level=0 and outputs at reset values in the same cycle.

Source files
------------

// File: rtl/elastic_buffer_sc.sv
// Single-clock elastic buffer with SKP-symbol rate compensation.
// Writes drop surplus SKPs when the buffer runs high; reads repeat a SKP
// at the head when the buffer runs low. A PRIME state holds off reads
// until the buffer has filled to TARGET_LEVEL.
module elastic_buffer_sc #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    BUFFER_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL   = 10'h0f3,
  parameter int                    TARGET_LEVEL = BUFFER_DEPTH / 2,
  parameter int                    HYSTERESIS   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_in_valid,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_out_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(BUFFER_DEPTH):0] level,
  output logic                          skp_added,
  output logic                          skp_removed,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  dvld_q, dvld_d;
  logic                  skp_added_q, skp_added_d;
  logic                  skp_removed_q, skp_removed_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Storage is never reset; a slot is only read after it has been written.
  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic                  skp_rm, wr_acc, pop;
  int                    lvl;

  assign head = mem[rd_ptr_q];
  assign lvl  = int'(level_q);

  // Write side: SKP removal, acceptance and overflow use the pre-edge level.
  always_comb begin
    skp_rm        = data_in_valid && (data_in == SKP_SYMBOL) &&
                    (lvl > TARGET_LEVEL + HYSTERESIS);
    wr_acc        = data_in_valid && !skp_rm && (lvl < BUFFER_DEPTH);
    skp_removed_d = skp_rm;
    overflow_d    = data_in_valid && !skp_rm && (lvl == BUFFER_DEPTH);
    wr_ptr_d      = wr_ptr_q + AW'(wr_acc);
  end

  // Read-side FSM: PRIME holds off reads, RUN pops or repeats a head SKP.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    dvld_d      = 1'b0;
    skp_added_d = 1'b0;
    underflow_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      PRIME: begin
        data_out_d = SKP_SYMBOL;
        if (lvl >= TARGET_LEVEL) state_d = RUN;
      end
      RUN: begin
        if (rd_en) begin
          if (lvl == 0) begin
            data_out_d  = SKP_SYMBOL;
            underflow_d = 1'b1;
            state_d     = PRIME;
          end else if ((head == SKP_SYMBOL) && (lvl < TARGET_LEVEL - HYSTERESIS)) begin
            // Replay the head SKP without consuming it to let the buffer refill.
            data_out_d  = SKP_SYMBOL;
            dvld_d      = 1'b1;
            skp_added_d = 1'b1;
          end else begin
            data_out_d = head;
            dvld_d     = 1'b1;
            pop        = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = PRIME;
    endcase
  end

  // Occupancy moves only when exactly one of write/pop happens.
  always_comb begin
    level_d = level_q + LW'(wr_acc) - LW'(pop);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= PRIME;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      data_out_q    <= SKP_SYMBOL;
      dvld_q        <= 1'b0;
      skp_added_q   <= 1'b0;
      skp_removed_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      data_out_q    <= data_out_d;
      dvld_q        <= dvld_d;
      skp_added_q   <= skp_added_d;
      skp_removed_q <= skp_removed_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Symbol storage write port.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  assign data_out       = data_out_q;
  assign data_out_valid = dvld_q;
  assign level          = level_q;
  assign full           = (lvl == BUFFER_DEPTH);
  assign empty          = (level_q == '0);
  assign skp_added      = skp_added_q;
  assign skp_removed    = skp_removed_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_elastic_buffer_sc.sv
// Directed bench for elastic_buffer_sc at depth 16, target 8, hysteresis 2.
module tb_elastic_buffer_sc;

  localparam logic [9:0] SKP = 10'h0f3;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data_in;
  logic       data_in_valid;
  logic       rd_en;
  logic [9:0] data_out;
  logic       data_out_valid;
  logic       full, empty;
  logic [4:0] level;
  logic       skp_added, skp_removed, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  elastic_buffer_sc dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .rd_en(rd_en), .data_out(data_out), .data_out_valid(data_out_valid),
    .full(full), .empty(empty), .level(level), .skp_added(skp_added),
    .skp_removed(skp_removed), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    logic       vin;
    logic       rd;
    logic [9:0] dout;
    logic       dval;
    logic [4:0] lvl;
    logic       unf;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and sample 1 time unit after the edge.
  task automatic cyc(input logic [9:0] din, input logic vin, input logic rd);
    data_in = din; data_in_valid = vin; rd_en = rd;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_in = '0; data_in_valid = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Priming, drain and underflow back to PRIME.
    for (int k = 1; k <= 8; k++)
      tbl[k-1] = '{10'(k), 1'b1, 1'b1, SKP, 1'b0, 5'(k), 1'b0};
    tbl[8] = '{10'h0, 1'b0, 1'b1, SKP, 1'b0, 5'd8, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[8+i] = '{10'h0, 1'b0, 1'b1, 10'(i), 1'b1, 5'(8-i), 1'b0};
    tbl[17] = '{10'h0,  1'b0, 1'b1, SKP, 1'b0, 5'd0, 1'b1};
    tbl[18] = '{10'h0aa, 1'b1, 1'b1, SKP, 1'b0, 5'd1, 1'b0};
    tbl[19] = '{10'h0bb, 1'b1, 1'b1, SKP, 1'b0, 5'd2, 1'b0};

    rst = 1'b1; data_in = '0; data_in_valid = 1'b0; rd_en = 1'b0;
    #1;
    chk("rst_dout", int'(data_out), int'(SKP));
    chk("rst_dval", int'(data_out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_pulses", int'({skp_added, skp_removed, overflow, underflow}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].din, tbl[i].vin, tbl[i].rd);
      chk($sformatf("vec%0d_dout", i), int'(data_out), int'(tbl[i].dout));
      chk($sformatf("vec%0d_dval", i), int'(data_out_valid), int'(tbl[i].dval));
      chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].lvl));
      chk($sformatf("vec%0d_unf", i), int'(underflow), int'(tbl[i].unf));
    end

    // SKP removal above target+hysteresis, storage at exactly target+hysteresis.
    do_reset();
    for (int i = 0; i < 12; i++) cyc(10'h100 + 10'(i), 1'b1, 1'b0);
    chk("rm_fill_level", int'(level), 12);
    cyc(SKP, 1'b1, 1'b0);
    chk("rm_level", int'(level), 12);
    chk("rm_pulse", int'(skp_removed), 1);
    cyc(10'h0, 1'b0, 1'b0);
    chk("rm_pulse_once", int'(skp_removed), 0);
    cyc(10'h0, 1'b0, 1'b1);
    chk("rm_pop0", int'(data_out), 'h100);
    cyc(10'h0, 1'b0, 1'b1);
    chk("rm_pop1", int'(data_out), 'h101);
    chk("rm_lvl10", int'(level), 10);
    cyc(SKP, 1'b1, 1'b0);
    chk("rm_store_at10_level", int'(level), 11);
    chk("rm_store_at10_pulse", int'(skp_removed), 0);
    cyc(SKP, 1'b1, 1'b0);
    chk("rm_at11_level", int'(level), 11);
    chk("rm_at11_pulse", int'(skp_removed), 1);

    // SKP insertion below target-hysteresis.
    do_reset();
    cyc(10'h201, 1'b1, 1'b0);
    cyc(10'h202, 1'b1, 1'b0);
    cyc(10'h203, 1'b1, 1'b0);
    cyc(SKP,     1'b1, 1'b0);
    for (int i = 4; i < 8; i++) cyc(10'h200 + 10'(i), 1'b1, 1'b0);
    cyc(10'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(10'h0, 1'b0, 1'b1);
      chk($sformatf("ins_pop%0d", i), int'(data_out), 'h200 + i);
    end
    chk("ins_lvl5", int'(level), 5);
    cyc(10'h0, 1'b0, 1'b1);
    chk("ins_dout", int'(data_out), int'(SKP));
    chk("ins_dval", int'(data_out_valid), 1);
    chk("ins_added", int'(skp_added), 1);
    chk("ins_level", int'(level), 5);
    cyc(10'h2aa, 1'b1, 1'b0);
    chk("ins_idle_dval", int'(data_out_valid), 0);
    chk("ins_idle_hold", int'(data_out), int'(SKP));
    chk("ins_lvl6", int'(level), 6);
    cyc(10'h0, 1'b0, 1'b1);
    chk("ins6_dout", int'(data_out), int'(SKP));
    chk("ins6_added", int'(skp_added), 0);
    chk("ins6_level", int'(level), 5);
    cyc(10'h0, 1'b0, 1'b1);
    chk("ins6_next", int'(data_out), 'h204);

    // Overflow: full buffer discards the extra symbol.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(10'h300 + 10'(i), 1'b1, 1'b0);
    chk("ovf_full_pre", int'(full), 1);
    cyc(10'h155, 1'b1, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_full", int'(full), 1);
    chk("ovf_level", int'(level), 16);
    cyc(10'h0, 1'b0, 1'b0);
    chk("ovf_pulse_once", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(10'h0, 1'b0, 1'b1);
      chk($sformatf("ovf_drain%0d", i), int'(data_out), 'h300 + i);
    end
    chk("ovf_empty", int'(empty), 1);

    // Wrap with concurrent write/read, then async reset mid-stream.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(10'h040 + 10'(i), 1'b1, 1'b0);
    cyc(10'h0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(10'h048 + 10'(i), 1'b1, 1'b1);
      chk($sformatf("wrap%0d_dout", i), int'(data_out), 'h040 + i);
      chk($sformatf("wrap%0d_level", i), int'(level), 8);
    end
    chk("pre_rst_dval", int'(data_out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_dout", int'(data_out), int'(SKP));
    chk("async_rst_dval", int'(data_out_valid), 0);
    chk("async_rst_empty", int'(empty), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(10'h0, 1'b0, 1'b1);
    chk("post_rst_prime_dval", int'(data_out_valid), 0);
    chk("post_rst_prime_unf", int'(underflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
